// File: rtl/obc_challenge_scheduler.sv
// Challenge/response health-check sequencer for the primary OBC: periodic question bursts,
// local answer check, escalation to an OBC reset pulse and finally a sticky failover.
module obc_challenge_scheduler #(
  parameter int         PERIOD      = 256,
  parameter int         N_ROUNDS    = 10,
  parameter int         PASS_MIN    = 10,
  parameter int         TIMEOUT     = 16,
  parameter int         MAX_STRIKES = 3,
  parameter int         RST_PULSE   = 8,
  parameter logic [3:0] LFSR_SEED   = 4'b1001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       q_valid,
  output logic [3:0] question,
  input  logic       q_ready,
  input  logic       a_valid,
  input  logic [3:0] answer_obc,
  output logic       obc_reset,
  output logic       override,
  output logic       busy,
  output logic [2:0] strikes,
  output logic [2:0] o_dbg_state
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_WAIT_PERIOD = 3'd1;
  localparam logic [2:0] S_ASK         = 3'd2;
  localparam logic [2:0] S_WAIT_ANS    = 3'd3;
  localparam logic [2:0] S_EVAL        = 3'd4;
  localparam logic [2:0] S_RESET_OBC   = 3'd5;
  localparam logic [2:0] S_FAILOVER    = 3'd6;

  localparam int TW = $clog2(PERIOD + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(RST_PULSE + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);
  localparam logic [3:0]    ROUNDS     = 4'(N_ROUNDS);
  localparam logic [3:0]    PASS_THR   = 4'(PASS_MIN);
  localparam logic [2:0]    STRIKE_MAX = 3'(MAX_STRIKES);

  // Handshake: a question transfers on a rising clk edge where q_valid & q_ready are both 1;
  // question is held stable while q_valid is high. Answers are a one-cycle a_valid strobe
  // and are only looked at while a question is outstanding (WAIT_ANS).

  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [WW-1:0] r_wcnt;
  logic [PW-1:0] r_pcnt;
  logic [3:0]    r_round;
  logic [3:0]    r_correct;
  logic [3:0]    r_expected;
  logic [3:0]    r_question;
  logic [2:0]    r_strikes;
  logic          r_q_valid;
  logic          r_obc_reset;
  logic          r_override;
  logic          r_busy;

  logic [2:0]    w_nxt;
  logic          w_hs;
  logic          w_ans_done;
  logic          w_hit;
  logic          w_pass;
  logic [3:0]    w_round_nxt;
  logic [2:0]    w_strikes_inc;
  logic [3:0]    w_ref_answer;

  always_comb begin
    w_ref_answer  = {r_question[3] ^ r_question[2], r_question[2] ^ r_question[1],
                     r_question[1] ^ r_question[0], ~r_question[0]};
    w_hs          = (r_state == S_ASK) && r_q_valid && q_ready;
    w_ans_done    = (r_state == S_WAIT_ANS) && (a_valid || (r_wcnt == WAIT_LAST));
    w_hit         = a_valid && (answer_obc == r_expected);
    w_round_nxt   = r_round + 4'd1;
    w_pass        = (r_correct >= PASS_THR);
    w_strikes_inc = r_strikes + 3'd1;
    w_nxt         = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) w_nxt = S_WAIT_PERIOD;
      end
      S_WAIT_PERIOD: begin
        if (!enable)                  w_nxt = S_IDLE;
        else if (r_timer == TIMER_LAST) w_nxt = S_ASK;
      end
      S_ASK: begin
        if (!enable)   w_nxt = S_IDLE;
        else if (w_hs) w_nxt = S_WAIT_ANS;
      end
      S_WAIT_ANS: begin
        if (!enable)        w_nxt = S_IDLE;
        else if (w_ans_done) w_nxt = (w_round_nxt < ROUNDS) ? S_ASK : S_EVAL;
      end
      S_EVAL: begin
        if (!enable)                       w_nxt = S_IDLE;
        else if (w_pass)                   w_nxt = S_WAIT_PERIOD;
        else if (w_strikes_inc == STRIKE_MAX) w_nxt = S_FAILOVER;
        else                               w_nxt = S_RESET_OBC;
      end
      S_RESET_OBC: begin
        if (r_pcnt == PULSE_LAST) w_nxt = S_WAIT_PERIOD;
      end
      S_FAILOVER: w_nxt = S_FAILOVER;
      default:    w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_wcnt      <= '0;
      r_pcnt      <= '0;
      r_round     <= '0;
      r_correct   <= '0;
      r_expected  <= '0;
      r_question  <= LFSR_SEED;
      r_strikes   <= '0;
      r_q_valid   <= 1'b0;
      r_obc_reset <= 1'b0;
      r_override  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      // Outputs are registered copies of what the next state implies.
      r_q_valid   <= (w_nxt == S_ASK);
      r_busy      <= (w_nxt == S_ASK) || (w_nxt == S_WAIT_ANS) || (w_nxt == S_EVAL);
      r_obc_reset <= (w_nxt == S_RESET_OBC);
      r_override  <= (w_nxt == S_FAILOVER);

      r_timer <= (r_state == S_WAIT_PERIOD) ? r_timer + TW'(1) : '0;
      r_wcnt  <= ((r_state == S_WAIT_ANS) && (w_nxt == S_WAIT_ANS)) ? r_wcnt + WW'(1) : '0;
      r_pcnt  <= ((r_state == S_RESET_OBC) && (w_nxt == S_RESET_OBC)) ? r_pcnt + PW'(1) : '0;

      if ((r_state == S_WAIT_PERIOD) && (w_nxt == S_ASK)) begin
        r_round   <= '0;
        r_correct <= '0;
      end else if (w_ans_done) begin
        r_round <= w_round_nxt;
        if (w_hit) r_correct <= r_correct + 4'd1;
      end

      if (w_hs) begin
        r_expected <= w_ref_answer;
        r_question <= {r_question[2:0], r_question[3] ^ r_question[2]};
      end

      // A burst abandoned by enable=0 leaves the strike count untouched.
      if ((r_state == S_EVAL) && enable) begin
        r_strikes <= w_pass ? 3'd0 : w_strikes_inc;
      end
    end
  end

  assign q_valid     = r_q_valid;
  assign question    = r_question;
  assign obc_reset   = r_obc_reset;
  assign override    = r_override;
  assign busy        = r_busy;
  assign strikes     = r_strikes;
  assign o_dbg_state = r_state;

endmodule
